// File: rtl/m_ext_pkg.sv
// Shared M-extension definitions: instruction encodings, frontend state
// encoding and the default operand width.
package m_ext_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RESP,
    ST_RELEASE
  } state_t;

  // Every funct3 with bit 2 set is one of DIV/DIVU/REM/REMU.
  function automatic logic is_div_insn(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV) && insn[14];
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// One-entry divide result cache: remembers the operands and both results of
// the last completed division so the complementary DIV/REM can skip the divider.
module div_result_cache
  import m_ext_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            fill_en,
  input  logic [XLEN-1:0] fill_a,
  input  logic [XLEN-1:0] fill_b,
  input  logic            fill_uns,
  input  logic [XLEN-1:0] fill_q,
  input  logic [XLEN-1:0] fill_r,
  input  logic [XLEN-1:0] look_a,
  input  logic [XLEN-1:0] look_b,
  input  logic            look_uns,
  output logic            hit,
  output logic [XLEN-1:0] hit_q,
  output logic [XLEN-1:0] hit_r
);

  logic            valid_q, valid_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d;

  always_comb begin
    valid_d = valid_q;
    uns_d   = uns_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    if (fill_en) begin
      valid_d = 1'b1;
      uns_d   = fill_uns;
      a_d     = fill_a;
      b_d     = fill_b;
      q_d     = fill_q;
      r_d     = fill_r;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) valid_q <= 1'b0;
    else         valid_q <= valid_d;
  end

  // The entry payload is only meaningful while valid_q is set.
  always_ff @(posedge clk) begin
    uns_q <= uns_d;
    a_q   <= a_d;
    b_q   <= b_d;
    q_q   <= q_d;
    r_q   <= r_d;
  end

  assign hit   = valid_q && (look_a == a_q) && (look_b == b_q) && (look_uns == uns_q);
  assign hit_q = q_q;
  assign hit_r = r_q;

endmodule

// File: rtl/pcpi_div_frontend.sv
// PCPI frontend for the serial divider: decodes DIV/DIVU/REM/REMU, drives the
// divider start/done handshake and returns the quotient or remainder.
module pcpi_div_frontend
  import m_ext_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready,
  output logic            div_start,
  output logic            div_unsigned,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic [XLEN-1:0] div_q,
  input  logic [XLEN-1:0] div_r,
  input  logic            div_done
);

  state_t          state_q, state_d;
  logic            abort_q, abort_d;
  logic            uns_q, uns_d, rem_q, rem_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;

  logic            match, accept, abort_now, fill_en;
  logic            hit;
  logic [XLEN-1:0] hit_q, hit_r;

  assign match     = is_div_insn(pcpi_insn);
  assign accept    = (state_q == ST_IDLE) && pcpi_valid && match;
  // A valid drop in the very cycle done arrives still counts as an abort.
  assign abort_now = abort_q || !pcpi_valid;
  assign fill_en   = (state_q == ST_RUN) && div_done && !abort_now;

  generate
    if (CACHE_EN) begin : g_cache
      div_result_cache #(.XLEN(XLEN)) u_cache (
        .clk     (clk),
        .resetn  (resetn),
        .fill_en (fill_en),
        .fill_a  (a_q),
        .fill_b  (b_q),
        .fill_uns(uns_q),
        .fill_q  (div_q),
        .fill_r  (div_r),
        .look_a  (pcpi_rs1),
        .look_b  (pcpi_rs2),
        .look_uns(pcpi_insn[12]),
        .hit     (hit),
        .hit_q   (hit_q),
        .hit_r   (hit_r)
      );
    end else begin : g_no_cache
      assign hit   = 1'b0;
      assign hit_q = '0;
      assign hit_r = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  // Operand/result registers are only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    uns_q <= uns_d;
    rem_q <= rem_d;
    a_q   <= a_d;
    b_q   <= b_d;
    res_q <= res_d;
  end

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    uns_d   = uns_q;
    rem_d   = rem_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          abort_d = 1'b0;
          uns_d   = pcpi_insn[12];
          rem_d   = pcpi_insn[13];
          a_d     = pcpi_rs1;
          b_d     = pcpi_rs2;
          res_d   = pcpi_insn[13] ? hit_r : hit_q;
          state_d = hit ? ST_RESP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!pcpi_valid) abort_d = 1'b1;
        if (div_done) begin
          res_d   = rem_q ? div_r : div_q;
          state_d = abort_now ? ST_RELEASE : ST_RESP;
        end
      end
      ST_RESP:    state_d = ST_RELEASE;
      ST_RELEASE: if (!div_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_start    = (state_q == ST_RUN);
    div_unsigned = (state_q == ST_RUN) && uns_q;
    div_a        = (state_q == ST_RUN) ? a_q : '0;
    div_b        = (state_q == ST_RUN) ? b_q : '0;
    pcpi_ready   = (state_q == ST_RESP);
    pcpi_wr      = (state_q == ST_RESP);
    pcpi_rd      = (state_q == ST_RESP) ? res_q : '0;
    pcpi_wait    = resetn && pcpi_valid && match && (state_q != ST_RELEASE);
  end

endmodule

// File: tb/tb_pcpi_div_frontend.sv
// Directed bench for pcpi_div_frontend with a cycle-accurate serial divider model.
module tb_pcpi_div_frontend;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            pcpi_valid = 1'b0;
  logic [31:0]     pcpi_insn = '0;
  logic [XLEN-1:0] pcpi_rs1 = '0;
  logic [XLEN-1:0] pcpi_rs2 = '0;
  logic            pcpi_wr, pcpi_wait, pcpi_ready;
  logic [XLEN-1:0] pcpi_rd;
  logic            div_start, div_unsigned, div_done;
  logic [XLEN-1:0] div_a, div_b, div_q, div_r;

  always #5 clk = ~clk;

  pcpi_div_frontend #(.XLEN(XLEN), .CACHE_EN(1'b1)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pcpi_valid  (pcpi_valid),
    .pcpi_insn   (pcpi_insn),
    .pcpi_rs1    (pcpi_rs1),
    .pcpi_rs2    (pcpi_rs2),
    .pcpi_wr     (pcpi_wr),
    .pcpi_rd     (pcpi_rd),
    .pcpi_wait   (pcpi_wait),
    .pcpi_ready  (pcpi_ready),
    .div_start   (div_start),
    .div_unsigned(div_unsigned),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_q       (div_q),
    .div_r       (div_r),
    .div_done    (div_done)
  );

  // Divider model: samples operands when idle with start high, finishes
  // 1 cycle later for special cases, else after 34 (unsigned) / 35 (signed).
  logic        m_busy, m_done;
  logic [5:0]  m_cnt;
  logic [63:0] m_res;

  function automatic logic m_special(input logic [31:0] a, input logic [31:0] b, input logic uns);
    return (b == 32'd0) || (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [63:0] m_divide(input logic [31:0] a, input logic [31:0] b, input logic uns);
    logic signed [31:0] sq, sr;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'd0};
    if (uns) return {a / b, a % b};
    sq = $signed(a) / $signed(b);
    sr = $signed(a) % $signed(b);
    return {sq, sr};
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= '0;
      m_res  <= '0;
    end else if (!m_busy) begin
      if (div_start) begin
        m_busy <= 1'b1;
        m_res  <= m_divide(div_a, div_b, div_unsigned);
        m_cnt  <= m_special(div_a, div_b, div_unsigned) ? 6'd0 : (div_unsigned ? 6'd33 : 6'd34);
      end
    end else if (!m_done) begin
      if (m_cnt == 6'd0) m_done <= 1'b1;
      else               m_cnt  <= m_cnt - 6'd1;
    end else if (!div_start) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  assign div_done = m_done;
  assign div_q    = m_res[63:32];
  assign div_r    = m_res[31:0];

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, ".ctl"}, 32'({pcpi_wait, pcpi_ready, pcpi_wr, div_start, div_unsigned}), 32'd0);
    chk({tag, ".rd"},  pcpi_rd, 32'd0);
    chk({tag, ".a"},   div_a, 32'd0);
    chk({tag, ".b"},   div_b, 32'd0);
  endtask

  // Issue one M-ext divide op (funct7=0000001) and check result and latency.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_rd, input int exp_cyc);
    int          cyc = 0;
    int          got_cyc = -1;
    logic [31:0] rd_seen = '0;
    logic        wr_seen = 1'b0;
    logic        start_seen = 1'b0;
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'b0000001, f3);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    while (got_cyc < 0 && cyc < 60) begin
      @(negedge clk);
      if (cyc == 0) chk({tag, ".wait"}, 32'(pcpi_wait), 32'd1);
      if (div_start) start_seen = 1'b1;
      if (cyc == 1 && exp_cyc > 1) begin
        chk({tag, ".div_a"}, div_a, a);
        chk({tag, ".div_b"}, div_b, b);
        chk({tag, ".div_uns"}, 32'(div_unsigned), 32'(f3[0]));
      end
      if (pcpi_ready) begin
        got_cyc = cyc;
        rd_seen = pcpi_rd;
        wr_seen = pcpi_wr;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".cycle"}, got_cyc, exp_cyc);
    chk({tag, ".rd"}, rd_seen, exp_rd);
    chk({tag, ".wr"}, 32'(wr_seen), 32'd1);
    chk({tag, ".start_used"}, 32'(start_seen), 32'(exp_cyc > 1));
    chk({tag, ".release_blocks"}, 32'({pcpi_wait, pcpi_ready}), 32'd0);
    pcpi_valid = 1'b0;
  endtask

  task automatic hold_nomatch(input string tag, input logic [31:0] insn);
    int hits = 0;
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = 32'd9;
    pcpi_rs2   = 32'd3;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pcpi_wait || pcpi_ready || div_start) hits++;
    end
    chk({tag, ".quiet"}, hits, 32'd0);
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
  endtask

  initial begin
    int readies;
    #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    run_op("div_neg",   3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 38);
    run_op("rem_hit",   3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1);
    run_op("divu_big",  3'b101, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 37);
    run_op("divu_zero", 3'b101, 32'd5,         32'd0,        32'hFFFF_FFFF, 4);
    run_op("remu_zero", 3'b111, 32'd5,         32'd0,        32'd5,         1);
    run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4);
    run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    hold_nomatch("mul",    mk_insn(7'b0000001, 3'b000));
    hold_nomatch("f7zero", mk_insn(7'b0000000, 3'b100));

    // Abort: drop valid at cycle 10 of a signed miss.
    readies = 0;
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'b0000001, 3'b100);
    pcpi_rs1   = 32'd100;
    pcpi_rs2   = 32'd7;
    for (int c = 0; c < 55; c++) begin
      @(negedge clk);
      if (pcpi_ready) readies++;
      if (c == 20) chk("abort.start_held", 32'(div_start), 32'd1);
      @(posedge clk); #1;
      if (c == 9) pcpi_valid = 1'b0;
    end
    chk("abort.no_ready", readies, 32'd0);
    chk("abort.quiet", 32'({div_done, div_start}), 32'd0);
    run_op("abort_refetch", 3'b100, 32'd100, 32'd7, 32'd14, 38);
    run_op("abort_rem_hit", 3'b110, 32'd100, 32'd7, 32'd2, 1);

    // Reset in the middle of an unsigned miss.
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'b0000001, 3'b101);
    pcpi_rs1   = 32'd100;
    pcpi_rs2   = 32'd7;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 19) chk("rst.mid_start", 32'(div_start), 32'd1);
      @(posedge clk); #1;
    end
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    @(posedge clk); #1;
    resetn = 1'b1;
    run_op("post_rst_div",  3'b100, 32'd100, 32'd7, 32'd14, 38);
    run_op("post_rst_divu", 3'b101, 32'd100, 32'd7, 32'd14, 37);
    run_op("post_rst_remu", 3'b111, 32'd100, 32'd7, 32'd2,  1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pcpi_div_frontend.md
# pcpi_div_frontend

Upstream control stage for the serial non-restoring divider in the M-extension coprocessor. It decodes DIV/DIVU/REM/REMU from PicoRV32's PCPI port and captures operands. It then runs the divider's start/done handshake and returns the quotient or remainder to the core. A one-entry result cache lets a DIV/REM pair on identical operands finish without a second division.

## Interface
- `XLEN`, default 32: operand/result width.
- `CACHE_EN`, default 1: 1 enables the one-entry result cache; 0 sends every op to the divider.
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `pcpi_valid` in 1: core presents an instruction.
- `pcpi_insn` in 32: instruction word.
- `pcpi_rs1` in XLEN: dividend.
- `pcpi_rs2` in XLEN: divisor.
- `pcpi_wr` out 1: write `pcpi_rd` to rd; pulses with `pcpi_ready`.
- `pcpi_rd` out XLEN: result.
- `pcpi_wait` out 1: instruction claimed, result pending.
- `pcpi_ready` out 1: result valid, one-cycle pulse.
- `div_start` out 1: divider start, level, held until released.
- `div_unsigned` out 1: selects unsigned divide.
- `div_a` out XLEN: divider dividend.
- `div_b` out XLEN: divider divisor.
- `div_q` in XLEN: divider quotient.
- `div_r` in XLEN: divider remainder.
- `div_done` in 1: divider finished; stays high while `div_start` is high.

## Operation
- **Decode (match):** `insn[6:0]`=0110011, `insn[31:25]`=0000001, `insn[14]`=1.
  - `funct3` 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - `insn[12]` selects unsigned; `insn[13]` selects remainder.
  - A non-match produces no `pcpi_wait` and no `pcpi_ready`.
- **`pcpi_wait`:** combinational, `pcpi_valid & match & (state != RELEASE)`.
- **IDLE:**
  - Accept when `pcpi_valid & match`.
  - Register rs1, rs2, unsigned flag and rem flag.
  - Cache hit → RESP. Miss → RUN.
- **Cache hit:** `CACHE_EN`, entry valid, and rs1, rs2 and unsigned flag all equal the stored values.
- **RUN:**
  - `div_start`=1; `div_a`/`div_b`/`div_unsigned` come from registers and stay stable the whole time.
  - Divider samples the operands in its first idle cycle with start high.
  - On `div_done`: capture `div_q`/`div_r`, fill the cache, go to RESP.
  - If `pcpi_valid` falls during RUN: set `abort`. On `div_done`, skip capture, cache fill and RESP, and go to RELEASE.
- **RESP:**
  - For one cycle: `pcpi_ready`=1, `pcpi_wr`=1, `pcpi_rd` = rem ? r : q.
  - `div_start`=0 from this cycle on. Next state RELEASE.
- **RELEASE:**
  - `div_start`=0; no new instruction is accepted.
  - Go to IDLE when `div_done`=0 (entered from the cache-hit path, this takes one cycle).
  - This guarantees the divider is back in its idle state before the next start.
- **Divider special cases (divide by zero, signed overflow):** passed through unmodified.
- **Cache:**
  - Stores {rs1, rs2, unsigned, q, r}.
  - Invalidated by reset only; overwritten by every completed miss.
- **Reset values:**
  - Outputs: all 0 (`pcpi_rd`, `div_a`, `div_b` = 0; every 1-bit output = 0).
  - Internal: state IDLE, `abort` 0, cache invalid.
- **Reset mid-operation:** immediate return to IDLE, no `pcpi_ready` emitted. The divider shares `resetn`.

## Timing
Cycle 0 is the IDLE cycle in which `pcpi_valid & match` is seen.
- **Miss, signed:**
  - `div_start` high from cycle 1; divider LOOP runs cycles 3-34; `div_done` at 37.
  - `pcpi_ready` at cycle 38.
- **Miss, unsigned:** `pcpi_ready` at cycle 37.
- **Zero divisor or signed overflow:** `div_done` at cycle 3, `pcpi_ready` at cycle 4.
- **Cache hit:** `pcpi_ready` at cycle 1.
- **Back-to-back instructions:** earliest re-accept is 2 cycles after `pcpi_ready` (one RELEASE cycle, then IDLE).
- **`pcpi_valid` in the cycle after ready:** ignored. The core drops `valid` on `ready`, and RELEASE blocks acceptance.

## Structure
- **Shared package `m_ext_pkg`:**
  - Opcode and funct7 constants.
  - funct3 codes for DIV/DIVU/REM/REMU.
  - State enum {IDLE, RUN, RESP, RELEASE}.
  - `XLEN` default.
- **Sub-module `div_result_cache`:**
  - Single entry: compare, fill, valid bit.
  - Instantiated only when `CACHE_EN`=1.
- **Divider:** instantiated beside this block at the coprocessor top, not inside it.

## Test plan
- **Signed divide:** DIV rs1=0xFFFFFFF9 (-7), rs2=2 → `pcpi_rd`=0xFFFFFFFD, `pcpi_wr`=1, `pcpi_ready` at cycle 38.
- **Cache hit:** REM with the same operands immediately after → `pcpi_ready` at cycle 1, `pcpi_rd`=0xFFFFFFFF, `div_start` never rises.
- **Divide by zero:** DIVU 5/0 → 0xFFFFFFFF at cycle 4; REMU 5/0 → 5 (cache hit).
- **Signed overflow:** DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- **Non-matching instructions:** MUL (funct3 000) and ADD (funct7 0) held valid 40 cycles → `pcpi_wait`, `pcpi_ready` and `div_start` stay 0.
- **Abort and reset:**
  - Drop `pcpi_valid` at cycle 10 → no `pcpi_ready`, cache not filled, IDLE reached after `div_done` falls.
  - Assert `resetn`=0 at cycle 20 → all outputs 0 immediately; the next DIVU 100/7 returns 14.
